ktane_mem_arbiter: RTL

Three-port round-robin arbiter that shares the single read/write port of the `ktane_mem` memory/peripheral map between the CPU and two auxiliary bus masters. The auxiliary masters are the display refresh engine and the timer/strike updater. The arbiter sits between these requesters and the memory's `data`/`read_addr`/`write_addr`/`we`/`re`/`q` pins. It issues at most one access per cycle and returns read data with a fixed latency.

---
 rtl/ktane_mem_arbiter_if.sv | 32 +++
 rtl/ktane_mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/ktane_mem_arbiter_if.sv
// rtl/ktane_mem_arbiter_if.sv - requester and memory-pin bundle for ktane_mem_arbiter
interface ktane_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]        req;
    logic [2:0]        we_in;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req, we_in, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req, we_in, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/ktane_mem_arbiter.sv
// rtl/ktane_mem_arbiter.sv - three-port round-robin arbiter for the ktane_mem port
// Registered issue stage; read data returns one cycle later tagged with its port.
module ktane_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    ktane_mem_arbiter_if.slave    bus
);
    logic [1:0]        r_ptr;
    logic [1:0]        r_idx;
    logic [1:0]        r_tag;
    logic              r_tag_vld;
    logic [2:0]        r_gnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;

    logic [2:0]        w_elig;
    logic [1:0]        w_cand0;
    logic [1:0]        w_cand1;
    logic [1:0]        w_cand2;
    logic              w_found;
    logic [1:0]        w_win;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A port granted this cycle is masked so it cannot win back-to-back.
    always_comb begin
        w_elig  = bus.req & ~r_gnt;
        w_cand0 = r_ptr;
        w_cand1 = next_port(r_ptr);
        w_cand2 = next_port(w_cand1);
        w_found = 1'b0;
        w_win   = r_ptr;
        if (w_elig[w_cand0]) begin
            w_found = 1'b1;
            w_win   = w_cand0;
        end else if (w_elig[w_cand1]) begin
            w_found = 1'b1;
            w_win   = w_cand1;
        end else if (w_elig[w_cand2]) begin
            w_found = 1'b1;
            w_win   = w_cand2;
        end
        case (w_win)
            2'd1: begin
                w_addr  = bus.addr1;
                w_wdata = bus.wdata1;
                w_we    = bus.we_in[1];
            end
            2'd2: begin
                w_addr  = bus.addr2;
                w_wdata = bus.wdata2;
                w_we    = bus.we_in[2];
            end
            default: begin
                w_addr  = bus.addr0;
                w_wdata = bus.wdata0;
                w_we    = bus.we_in[0];
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr       <= 2'd0;
            r_idx       <= 2'd0;
            r_tag       <= 2'd0;
            r_tag_vld   <= 1'b0;
            r_gnt       <= 3'b000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            r_gnt     <= w_found ? (3'b001 << w_win) : 3'b000;
            r_mem_we  <= w_found & w_we;
            r_mem_re  <= w_found & ~w_we;
            r_tag_vld <= r_mem_re;
            r_tag     <= r_idx;
            if (w_found) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                r_idx       <= w_win;
                r_ptr       <= next_port(w_win);
            end
        end
    end

    // Read return is combinational from mem_q, steered by the registered tag.
    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_tag_vld ? (3'b001 << r_tag) : 3'b000;
    assign bus.rdata     = r_tag_vld ? bus.mem_q : '0;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
endmodule
